// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw key lines in, debounced level and event pulses out.
interface key_debouncer_if #(
  parameter int unsigned N_KEYS = 3
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;
  logic              sample_tick;

  modport master (
    output key_raw,
    input  key_level, key_press, key_release, key_repeat, sample_tick
  );

  modport slave (
    input  key_raw,
    output key_level, key_press, key_release, key_repeat, sample_tick
  );
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: per-key 2-flop synchroniser, tick-sampled debounce, press/release pulses.
// Auto-repeat on held keys is built only when KEY_DEBOUNCER_REPEAT_EN is defined.
module key_debouncer #(
  parameter int unsigned N_KEYS     = 3,
  parameter int unsigned TICK_DIV   = 500,
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned REPEAT_DLY = 100,
  parameter int unsigned REPEAT_PER = 20
) (
  input  logic           clk100khz,
  input  logic           rst,
  key_debouncer_if.slave bus
);
  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned STB_W  = $clog2(STABLE_CNT + 1);

  if (N_KEYS < 1 || TICK_DIV < 2 || STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_param
    $error("key_debouncer: illegal parameter value");
  end

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_level;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_sample_tick;
  logic [STB_W-1:0]  r_stb_cnt [N_KEYS];

  logic [TICK_W-1:0] w_tick_next;
  logic [STB_W-1:0]  w_stb_next [N_KEYS];
  logic [N_KEYS-1:0] w_toggle;

  // sample_tick is registered one cycle ahead so it is high exactly while the count is TICK_DIV-1
  always_comb begin
    w_tick_next = r_tick_cnt + TICK_W'(1);
    if (r_tick_cnt == TICK_W'(TICK_DIV - 1)) begin
      w_tick_next = '0;
    end
  end

  // Any sample matching the current level restarts the count; reaching STABLE_CNT toggles
  always_comb begin
    w_toggle = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      w_stb_next[i] = r_stb_cnt[i];
      if (r_sample_tick) begin
        if (r_sync2[i] == r_level[i]) begin
          w_stb_next[i] = '0;
        end else if (r_stb_cnt[i] + STB_W'(1) == STB_W'(STABLE_CNT)) begin
          w_toggle[i]   = 1'b1;
          w_stb_next[i] = '0;
        end else begin
          w_stb_next[i] = r_stb_cnt[i] + STB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk100khz or posedge rst) begin
    if (rst) begin
      r_sync1       <= '1;
      r_sync2       <= '1;
      r_tick_cnt    <= '0;
      r_sample_tick <= 1'b0;
      r_level       <= '1;
      r_press       <= '0;
      r_release     <= '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        r_stb_cnt[i] <= '0;
      end
    end else begin
      r_sync1       <= bus.key_raw;
      r_sync2       <= r_sync1;
      r_tick_cnt    <= w_tick_next;
      r_sample_tick <= (w_tick_next == TICK_W'(TICK_DIV - 1));
      r_level       <= r_level ^ w_toggle;
      r_press       <= w_toggle & r_level;
      r_release     <= w_toggle & ~r_level;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        r_stb_cnt[i] <= w_stb_next[i];
      end
    end
  end

`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold_cnt [N_KEYS];
  logic [N_KEYS-1:0] r_hold_phase;
  logic [N_KEYS-1:0] r_repeat;
  logic [HOLD_W-1:0] w_hold_next [N_KEYS];
  logic [N_KEYS-1:0] w_phase_next;
  logic [N_KEYS-1:0] w_rep_fire;

  // Phase 0 waits REPEAT_DLY held ticks, phase 1 re-arms every REPEAT_PER; a release tick wins
  always_comb begin
    w_phase_next = r_hold_phase;
    w_rep_fire   = '0;
    for (int i = 0; i < int'(N_KEYS); i++) begin
      w_hold_next[i] = r_hold_cnt[i];
      if (r_sample_tick) begin
        if (r_level[i] || w_toggle[i]) begin
          w_hold_next[i]  = '0;
          w_phase_next[i] = 1'b0;
        end else if (r_hold_cnt[i] + HOLD_W'(1) ==
                     (r_hold_phase[i] ? HOLD_W'(REPEAT_PER) : HOLD_W'(REPEAT_DLY))) begin
          w_hold_next[i]  = '0;
          w_phase_next[i] = 1'b1;
          w_rep_fire[i]   = 1'b1;
        end else begin
          w_hold_next[i] = r_hold_cnt[i] + HOLD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk100khz or posedge rst) begin
    if (rst) begin
      r_hold_phase <= '0;
      r_repeat     <= '0;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        r_hold_cnt[i] <= '0;
      end
    end else begin
      r_hold_phase <= w_phase_next;
      r_repeat     <= w_rep_fire;
      for (int i = 0; i < int'(N_KEYS); i++) begin
        r_hold_cnt[i] <= w_hold_next[i];
      end
    end
  end

  assign bus.key_repeat = r_repeat;
`else
  assign bus.key_repeat = '0;
`endif

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.sample_tick = r_sample_tick;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed key scenarios; expected pulses are queued and checked by a monitor.
module tb_key_debouncer;
  localparam int unsigned N_KEYS     = 3;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned STABLE_CNT = 3;
  localparam int unsigned REPEAT_DLY = 5;
  localparam int unsigned REPEAT_PER = 2;

  typedef struct {
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] rep;
    logic [2:0] level;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];

  key_debouncer_if #(.N_KEYS(N_KEYS)) bus ();

  key_debouncer #(
    .N_KEYS(N_KEYS), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT),
    .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)
  ) u_dut (
    .clk100khz(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Cycle stamp: equals the number of rising edges since rst was released
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input logic [2:0] press, input logic [2:0] rel, input logic [2:0] rep,
                         input logic [2:0] level, input int c);
    ev_t e;
    e.press = press; e.rel = rel; e.rep = rep; e.level = level; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    bus.key_raw = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Monitor: every cycle with a pulse consumes one expected event
  always @(negedge clk) begin
    ev_t e;
    if (!rst && ((bus.key_press | bus.key_release | bus.key_repeat) != 3'b000)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: press=%b release=%b repeat=%b level=%b cycle=%0d, required no pulse",
                 bus.key_press, bus.key_release, bus.key_repeat, bus.key_level, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.key_press !== e.press || bus.key_release !== e.rel || bus.key_repeat !== e.rep ||
            bus.key_level !== e.level || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL event: got press=%b release=%b repeat=%b level=%b cycle=%0d, required press=%b release=%b repeat=%b level=%b cycle=%0d",
                   bus.key_press, bus.key_release, bus.key_repeat, bus.key_level, cyc,
                   e.press, e.rel, e.rep, e.level, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_raw = '1;

    // Asynchronous reset values
    #2 rst = 1'b1;
    #1;
    check("rst_level",   32'(bus.key_level),   32'h7);
    check("rst_press",   32'(bus.key_press),   32'h0);
    check("rst_release", 32'(bus.key_release), 32'h0);
    check("rst_repeat",  32'(bus.key_repeat),  32'h0);
    check("rst_tick",    32'(bus.sample_tick), 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Tick phase: high only in cycles 3 and 7 after release
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check("tick_phase", 32'(bus.sample_tick), (c == 3 || c == 7) ? 32'd1 : 32'd0);
    end

    // Clean press and release on key 0
    reset_dut();
    push_ev(3'b001, 3'b000, 3'b000, 3'b110, 12);
    push_ev(3'b000, 3'b001, 3'b000, 3'b111, 24);
    bus.key_raw = 3'b110;
    goto(12);
    bus.key_raw = 3'b111;
    goto(30);
    drain("clean_drained");

    // Bounce on key 1: samples 0,1,0,0,0
    reset_dut();
    push_ev(3'b010, 3'b000, 3'b000, 3'b101, 20);
    push_ev(3'b000, 3'b010, 3'b000, 3'b111, 32);
    bus.key_raw = 3'b101;
    goto(4);
    bus.key_raw = 3'b111;
    goto(8);
    bus.key_raw = 3'b101;
    goto(20);
    bus.key_raw = 3'b111;
    goto(38);
    drain("bounce_drained");

    // All keys in the same cycle
    reset_dut();
    push_ev(3'b111, 3'b000, 3'b000, 3'b000, 12);
    push_ev(3'b000, 3'b111, 3'b000, 3'b111, 24);
    bus.key_raw = 3'b000;
    goto(12);
    bus.key_raw = 3'b111;
    goto(30);
    drain("simul_drained");

    // Key 2 held: held tick n lands on cycle 12+4n; repeats at n=5,7,...,31; release at 144
    reset_dut();
    push_ev(3'b100, 3'b000, 3'b000, 3'b011, 12);
`ifdef KEY_DEBOUNCER_REPEAT_EN
    for (int n = 5; n <= 31; n += 2) push_ev(3'b000, 3'b000, 3'b100, 3'b011, 12 + 4 * n);
`endif
    push_ev(3'b000, 3'b100, 3'b000, 3'b111, 144);
    bus.key_raw = 3'b011;
    goto(132);
    bus.key_raw = 3'b111;
    goto(150);
    drain("repeat_drained");

    // Reset while key 0 held and key 1 mid-debounce
    reset_dut();
    push_ev(3'b001, 3'b000, 3'b000, 3'b110, 12);
    bus.key_raw = 3'b110;
    goto(12);
    bus.key_raw = 3'b100;
    goto(21);
    rst = 1'b1;
    #1;
    check("midrst_level",   32'(bus.key_level),   32'h7);
    check("midrst_press",   32'(bus.key_press),   32'h0);
    check("midrst_release", 32'(bus.key_release), 32'h0);
    check("midrst_repeat",  32'(bus.key_repeat),  32'h0);
    check("midrst_tick",    32'(bus.sample_tick), 32'h0);
    check("midrst_queue",   32'(exp_q.size()),    32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    push_ev(3'b011, 3'b000, 3'b000, 3'b100, 12);
    push_ev(3'b000, 3'b011, 3'b000, 3'b111, 32);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("first_tick", 32'(bus.sample_tick), (c == 3) ? 32'd1 : 32'd0);
    end
    goto(20);
    bus.key_raw = 3'b111;
    goto(38);
    drain("midrst_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
